// File: rtl/board_io_pkg.sv
// Shared constants and helpers for the board I/O front-end.
// Holds the default synchroniser/debounce settings, the PWM counter width and the counter-width function.
package board_io_pkg;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 250000;
    localparam int PWM_W               = 8;

    // The counter has to be able to hold values from 0 up to the cycle count itself.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/board_io_ctrl_if.sv
// Board I/O bus: switch levels and edges, interrupt control, and the LED request and drive signals.
// The i_led_duty signal exists only when BOARD_IO_PWM_EN is defined. master = GPIO/board side, slave = board_io_ctrl.
interface board_io_ctrl_if #(
    parameter int NUM_SW  = 8,
    parameter int NUM_LED = 8
);
    import board_io_pkg::*;

    logic [NUM_SW-1:0]  i_sw;
    logic [NUM_SW-1:0]  o_sw_level;
    logic [NUM_SW-1:0]  o_sw_rise;
    logic [NUM_SW-1:0]  o_sw_fall;
    logic [NUM_SW-1:0]  i_irq_mask;
    logic [NUM_SW-1:0]  i_irq_clr;
    logic [NUM_SW-1:0]  o_irq_pending;
    logic               o_irq;
    logic [NUM_LED-1:0] i_led;
    logic [NUM_LED-1:0] o_led;
`ifdef BOARD_IO_PWM_EN
    logic [PWM_W-1:0]   i_led_duty;
`endif

    modport master (
`ifdef BOARD_IO_PWM_EN
        output i_led_duty,
`endif
        output i_sw, i_irq_mask, i_irq_clr, i_led,
        input  o_sw_level, o_sw_rise, o_sw_fall, o_irq_pending, o_irq, o_led
    );

    modport slave (
`ifdef BOARD_IO_PWM_EN
        input  i_led_duty,
`endif
        input  i_sw, i_irq_mask, i_irq_clr, i_led,
        output o_sw_level, o_sw_rise, o_sw_fall, o_irq_pending, o_irq, o_led
    );

endinterface

// File: rtl/board_io_debounce.sv
// One switch channel: synchroniser chain, debounce counter, stable level and one-cycle rise/fall pulses.
// A pin change reaches o_level after SYNC_STAGES+DEBOUNCE_CYCLES cycles. The edge pulses are registered and are set together with o_level.
module board_io_debounce
    import board_io_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int             CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_stable;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync   <= '0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            // A glitch returns sync to stable before the count expires, so the count starts again from zero.
            if (w_sync == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= w_sync;
                r_cnt    <= '0;
                r_rise   <= w_sync;
                r_fall   <= ~w_sync;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_stable;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O front-end: per-channel debounce and edges, sticky maskable interrupt, and a 2-register LED output stage.
// Latency: o_irq follows pending by 1 cycle and o_led follows i_led by 2 cycles. BOARD_IO_PWM_EN gates the LEDs with a global duty cycle.
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int NUM_SW          = 8,
    parameter int NUM_LED         = 8,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst,
    board_io_ctrl_if.slave  bus
);

    logic [NUM_SW-1:0]  w_level;
    logic [NUM_SW-1:0]  w_rise;
    logic [NUM_SW-1:0]  w_fall;
    logic [NUM_SW-1:0]  r_pending;
    logic               r_irq;
    logic [NUM_LED-1:0] r_led_s1;
    logic [NUM_LED-1:0] r_led_s2;
    logic [NUM_LED-1:0] w_led_gate;

    for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
        board_io_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .rst     (rst),
            .i_pin   (bus.i_sw[g]),
            .o_level (w_level[g]),
            .o_rise  (w_rise[g]),
            .o_fall  (w_fall[g])
        );
    end

    // A set in the same cycle as a clear wins. The mask only gates new sets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~bus.i_irq_clr) | ((w_rise | w_fall) & bus.i_irq_mask);
            r_irq     <= |r_pending;
        end
    end

`ifdef BOARD_IO_PWM_EN
    logic [PWM_W-1:0] r_pwm_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    assign w_led_gate = {NUM_LED{r_pwm_cnt < bus.i_led_duty}};
`else
    assign w_led_gate = '1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led_s1 <= '0;
            r_led_s2 <= '0;
        end else begin
            r_led_s1 <= bus.i_led;
            r_led_s2 <= r_led_s1 & w_led_gate;
        end
    end

    assign bus.o_sw_level    = w_level;
    assign bus.o_sw_rise     = w_rise;
    assign bus.o_sw_fall     = w_fall;
    assign bus.o_irq_pending = r_pending;
    assign bus.o_irq         = r_irq;
    assign bus.o_led         = r_led_s2;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed self-checking bench for board_io_ctrl with DEBOUNCE_CYCLES=16, SYNC_STAGES=2 and 8 switch/LED channels.
// The PWM scenario is compiled in only when BOARD_IO_PWM_EN is defined.
module tb_board_io_ctrl;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    board_io_ctrl_if #(.NUM_SW(8), .NUM_LED(8)) bus ();

    board_io_ctrl #(
        .NUM_SW          (8),
        .NUM_LED         (8),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int first;
        int rises;
        rst            = 1'b1;
        bus.i_sw       = 8'hFF;
        bus.i_irq_mask = 8'h00;
        bus.i_irq_clr  = 8'h00;
        bus.i_led      = 8'h00;
`ifdef BOARD_IO_PWM_EN
        bus.i_led_duty = 8'd0;
`endif
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if ({bus.o_sw_level, bus.o_sw_rise, bus.o_sw_fall, bus.o_irq_pending, bus.o_led, bus.o_irq} !== 41'd0) begin
                failures++;
                $display("FAIL reset_outputs cycle %0d: lvl=%h rise=%h fall=%h pend=%h led=%h irq=%b, want all 0",
                         c, bus.o_sw_level, bus.o_sw_rise, bus.o_sw_fall, bus.o_irq_pending, bus.o_led, bus.o_irq);
            end
        end
        rst   = 1'b0;
        first = 0;
        rises = 0;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (bus.o_sw_level === 8'hFF && first == 0) first = c;
            if (bus.o_sw_rise === 8'hFF) rises++;
        end
        checks++;
        if (first < 17 || first > 19) begin
            failures++;
            $display("FAIL reset_accept_latency: got %0d cycles, want 18 +/- 1", first);
        end
        checks++;
        if (rises != 1) begin
            failures++;
            $display("FAIL reset_rise_pulse: got %0d cycles of rise=FF, want 1", rises);
        end
        checks++;
        if (bus.o_sw_rise !== 8'h00 || bus.o_sw_fall !== 8'h00) begin
            failures++;
            $display("FAIL reset_edges_idle: rise=%h fall=%h, want 00/00", bus.o_sw_rise, bus.o_sw_fall);
        end
    endtask

    task automatic test_glitch;
        int bad;
        int first;
        int rises;
        bus.i_sw = 8'h00;
        repeat (25) tick();
        checks++;
        if (bus.o_sw_level !== 8'h00) begin
            failures++;
            $display("FAIL glitch_settle_low: level=%h, want 00", bus.o_sw_level);
        end
        bus.i_sw = 8'h08;
        repeat (10) tick();
        bus.i_sw = 8'h00;
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus.o_sw_level[3] !== 1'b0 || bus.o_sw_rise[3] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL glitch_rejected: level/rise[3] high on %0d cycles, want 0", bad);
        end
        bus.i_sw = 8'h08;
        first = 0;
        rises = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (bus.o_sw_level[3] === 1'b1 && first == 0) first = c;
            if (bus.o_sw_rise[3] === 1'b1) rises++;
        end
        checks++;
        if (first < 17 || first > 19) begin
            failures++;
            $display("FAIL glitch_hold_latency: got %0d cycles, want 18 +/- 1", first);
        end
        checks++;
        if (rises != 1 || bus.o_sw_level !== 8'h08) begin
            failures++;
            $display("FAIL glitch_hold_rise: rises=%0d level=%h, want 1 and 08", rises, bus.o_sw_level);
        end
    endtask

    task automatic test_irq;
        int seen;
        bus.i_irq_mask = 8'h01;
        checks++;
        if (bus.o_irq_pending !== 8'h00 || bus.o_irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_idle: pend=%h irq=%b, want 00/0", bus.o_irq_pending, bus.o_irq);
        end
        bus.i_sw = 8'h0B;
        seen = 0;
        for (int c = 0; c < 30 && seen == 0; c++) begin
            tick();
            if (bus.o_irq_pending !== 8'h00) seen = 1;
        end
        checks++;
        if (seen == 0 || bus.o_irq_pending !== 8'h01 || bus.o_irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_pending_set: seen=%0d pend=%h irq=%b, want 1/01/0", seen, bus.o_irq_pending, bus.o_irq);
        end
        tick();
        checks++;
        if (bus.o_irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_assert: irq=%b, want 1", bus.o_irq);
        end
        bus.i_irq_clr = 8'h01;
        tick();
        bus.i_irq_clr = 8'h00;
        checks++;
        if (bus.o_irq_pending !== 8'h00 || bus.o_irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_clear_pending: pend=%h irq=%b, want 00/1", bus.o_irq_pending, bus.o_irq);
        end
        tick();
        checks++;
        if (bus.o_irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_deassert: irq=%b, want 0", bus.o_irq);
        end
    endtask

    task automatic test_collision;
        int seen;
        bus.i_irq_clr = 8'h01;
        bus.i_sw      = 8'h0A;
        repeat (25) tick();
        checks++;
        if (bus.o_irq_pending !== 8'h00 || bus.o_sw_level !== 8'h0A) begin
            failures++;
            $display("FAIL coll_setup: pend=%h level=%h, want 00/0A", bus.o_irq_pending, bus.o_sw_level);
        end
        bus.i_sw = 8'h0B;
        seen = 0;
        for (int c = 0; c < 30 && seen == 0; c++) begin
            tick();
            if (bus.o_sw_rise[0] === 1'b1) seen = 1;
        end
        tick();
        checks++;
        if (seen == 0 || bus.o_irq_pending[0] !== 1'b1) begin
            failures++;
            $display("FAIL coll_set_wins: seen=%0d pend=%h, want 1 and bit0 set", seen, bus.o_irq_pending);
        end
        tick();
        checks++;
        if (bus.o_irq_pending[0] !== 1'b0) begin
            failures++;
            $display("FAIL coll_clear_after: pend=%h, want bit0 clear", bus.o_irq_pending);
        end
        bus.i_irq_clr = 8'h00;
    endtask

`ifndef BOARD_IO_PWM_EN
    task automatic test_led_path;
        bus.i_led = 8'hA5;
        tick();
        checks++;
        if (bus.o_led !== 8'h00) begin
            failures++;
            $display("FAIL led_delay1: led=%h, want 00", bus.o_led);
        end
        bus.i_led = 8'h00;
        tick();
        checks++;
        if (bus.o_led !== 8'hA5) begin
            failures++;
            $display("FAIL led_delay2: led=%h, want A5", bus.o_led);
        end
        tick();
        checks++;
        if (bus.o_led !== 8'h00) begin
            failures++;
            $display("FAIL led_one_cycle: led=%h, want 00", bus.o_led);
        end
    endtask
`else
    task automatic test_pwm;
        int cnt [8];
        bus.i_led      = 8'hFF;
        bus.i_led_duty = 8'd64;
        repeat (3) tick();
        for (int b = 0; b < 8; b++) cnt[b] = 0;
        for (int c = 0; c < 256; c++) begin
            tick();
            for (int b = 0; b < 8; b++) if (bus.o_led[b] === 1'b1) cnt[b]++;
        end
        for (int b = 0; b < 8; b++) begin
            checks++;
            if (cnt[b] != 64) begin
                failures++;
                $display("FAIL pwm_duty64 bit %0d: high %0d cycles, want 64", b, cnt[b]);
            end
        end
        bus.i_led_duty = 8'd0;
        repeat (3) tick();
        for (int b = 0; b < 8; b++) cnt[b] = 0;
        for (int c = 0; c < 256; c++) begin
            tick();
            for (int b = 0; b < 8; b++) if (bus.o_led[b] === 1'b1) cnt[b]++;
        end
        for (int b = 0; b < 8; b++) begin
            checks++;
            if (cnt[b] != 0) begin
                failures++;
                $display("FAIL pwm_duty0 bit %0d: high %0d cycles, want 0", b, cnt[b]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_glitch();
        test_irq();
        test_collision();
`ifndef BOARD_IO_PWM_EN
        test_led_path();
`else
        test_pwm();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
